// File: rtl/vrf_seq_nport_if.sv
// Bus bundle for the vector register file: operand fetch handshake, write
// handshake and mask shadow read. Signal suffixes are relative to the
// register file (the slave side).
interface vrf_seq_nport_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int ELEMS      = 4,
  parameter int RD_PORTS   = 3
);
  localparam int ADDR_B = $clog2(REG_NUM);
  localparam int ELEM_B = $clog2(ELEMS);
  localparam int BE_W   = DATA_WIDTH / 8;

  // Operand fetch
  logic                           rd_req_i;
  logic                           rd_ready_o;
  logic [RD_PORTS-1:0]            rd_port_en_i;
  logic [RD_PORTS*ADDR_B-1:0]     rd_addr_i;
  logic                           rd_valid_o;
  logic [ELEM_B-1:0]              rd_elem_i;
  logic [RD_PORTS*DATA_WIDTH-1:0] rd_data_o;

  // Element write
  logic                           wr_valid_i;
  logic                           wr_ready_o;
  logic [ADDR_B-1:0]              wr_addr_i;
  logic [ELEM_B-1:0]              wr_elem_i;
  logic [BE_W-1:0]                wr_be_i;
  logic [DATA_WIDTH-1:0]          wdata_i;

  // Mask shadow
  logic                           mask_en_i;
  logic [DATA_WIDTH-1:0]          mask_rdata_o;

  modport slave (
    input  rd_req_i, rd_port_en_i, rd_addr_i, rd_elem_i,
    output rd_ready_o, rd_valid_o, rd_data_o,
    input  wr_valid_i, wr_addr_i, wr_elem_i, wr_be_i, wdata_i,
    output wr_ready_o,
    input  mask_en_i,
    output mask_rdata_o
  );

  modport master (
    output rd_req_i, rd_port_en_i, rd_addr_i, rd_elem_i,
    input  rd_ready_o, rd_valid_o, rd_data_o,
    output wr_valid_i, wr_addr_i, wr_elem_i, wr_be_i, wdata_i,
    input  wr_ready_o,
    output mask_en_i,
    input  mask_rdata_o
  );
endinterface

// File: rtl/vrf_seq_nport.sv
// Flip-flop vector register file for one lane group. Operands are fetched
// one enabled port per cycle into per-port buffers; writes are byte-enabled
// and forwarded into a capture happening in the same cycle. Element 0 of v0
// is mirrored in a mask shadow register.
module vrf_seq_nport #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int ELEMS      = 4,
  parameter int RD_PORTS   = 3
) (
  input logic             clk_i,
  input logic             resetn_i,
  vrf_seq_nport_if.slave  bus
);
  localparam int ADDR_B = $clog2(REG_NUM);
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int PORT_B = (RD_PORTS > 1) ? $clog2(RD_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;
  typedef logic [DATA_WIDTH-1:0] word_t;

  state_e              state_q, state_d;
  logic [RD_PORTS-1:0] en_q, en_d;
  logic [ADDR_B-1:0]   addr_q [RD_PORTS];
  logic [ADDR_B-1:0]   addr_d [RD_PORTS];
  logic [PORT_B-1:0]   port_q, port_d;
  word_t               opbuf_q [RD_PORTS][ELEMS];
  word_t               opbuf_d [RD_PORTS][ELEMS];
  word_t               mem_q [REG_NUM][ELEMS];
  word_t               mem_d [REG_NUM][ELEMS];
  word_t               mask_q, mask_d;

  logic                wr_fire;
  word_t               wr_merged;
  logic [PORT_B-1:0]   first_port, next_port;
  logic                has_next;
  logic [ADDR_B-1:0]   cap_addr;

  function automatic word_t be_merge(word_t old_w, word_t new_w, logic [BE_W-1:0] be);
    word_t r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  assign bus.wr_ready_o = resetn_i;
  assign wr_fire        = bus.wr_valid_i && bus.wr_ready_o;
  assign wr_merged      = be_merge(mem_q[bus.wr_addr_i][bus.wr_elem_i], bus.wdata_i, bus.wr_be_i);

  // Next storage and mask shadow contents after a fired write
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    mem_d  = mem_q;
    mask_d = mask_q;
    if (wr_fire) begin
      mem_d[bus.wr_addr_i][bus.wr_elem_i] = wr_merged;
      if (bus.wr_addr_i == '0 && bus.wr_elem_i == '0)
        mask_d = be_merge(mask_q, bus.wdata_i, bus.wr_be_i);
    end
  end

  // Register storage and mask shadow
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      // NOTE: the array is plain flops and must read as zero after reset, so every entry is reset explicitly.
      for (int r = 0; r < REG_NUM; r++)
        for (int e = 0; e < ELEMS; e++) mem_q[r][e] <= '0;
      mask_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      mem_q  <= mem_d;
      mask_q <= mask_d;
    end
  end

  // Lowest enabled port on acceptance, and next enabled port above the current one
  always_comb begin
    first_port = '0;
    next_port  = '0;
    has_next   = 1'b0;
    for (int p = RD_PORTS - 1; p >= 0; p--) begin
      if (bus.rd_port_en_i[p]) first_port = PORT_B'(p);
      if (en_q[p] && (p > int'(port_q))) begin
        next_port = PORT_B'(p);
        has_next  = 1'b1;
      end
    end
  end

  // Fetch sequencer: accept, capture one enabled port per cycle, then pulse valid
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    addr_d   = addr_q;
    port_d   = port_q;
    opbuf_d  = opbuf_q;
    cap_addr = addr_q[port_q];
    case (state_q)
      IDLE: begin
        if (bus.rd_req_i) begin
          en_d   = bus.rd_port_en_i;
          port_d = first_port;
          for (int p = 0; p < RD_PORTS; p++) begin
            addr_d[p] = bus.rd_addr_i[p*ADDR_B +: ADDR_B];
            if (!bus.rd_port_en_i[p])
              for (int e = 0; e < ELEMS; e++) opbuf_d[p][e] = '0;
          end
          state_d = (|bus.rd_port_en_i) ? FETCH : DONE;
        end
      end
      FETCH: begin
        for (int e = 0; e < ELEMS; e++) opbuf_d[port_q][e] = mem_q[cap_addr][e];
        // A write to the register being captured this cycle is forwarded
        if (wr_fire && bus.wr_addr_i == cap_addr)
          opbuf_d[port_q][bus.wr_elem_i] = wr_merged;
        if (has_next) port_d = next_port;
        else          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fetch sequencer state and operand buffers
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      en_q    <= '0;
      port_q  <= '0;
      for (int p = 0; p < RD_PORTS; p++) begin
        addr_q[p] <= '0;
        for (int e = 0; e < ELEMS; e++) opbuf_q[p][e] <= '0;
      end
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      opbuf_q <= opbuf_d;
    end
  end

  assign bus.rd_ready_o   = resetn_i && (state_q == IDLE);
  assign bus.rd_valid_o   = (state_q == DONE);
  assign bus.mask_rdata_o = bus.mask_en_i ? mask_q : '0;

  // Operand outputs: selected element of each buffer
  always_comb begin
    bus.rd_data_o = '0;
    for (int p = 0; p < RD_PORTS; p++)
      bus.rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = opbuf_q[p][bus.rd_elem_i];
  end
endmodule

// File: tb/tb_vrf_seq_nport.sv
// Directed bench for vrf_seq_nport: reset state, fetch latency, disabled
// ports, byte enables with mask shadow, write forwarding, empty fetch and
// reset in the middle of a fetch.
module tb_vrf_seq_nport;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vrf_seq_nport_if bus ();

  vrf_seq_nport dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int e, input logic [31:0] d, input logic [3:0] be);
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 5'(a);
    bus.wr_elem_i  = 2'(e);
    bus.wdata_i    = d;
    bus.wr_be_i    = be;
    tick();
    bus.wr_valid_i = 1'b0;
  endtask

  function automatic logic [14:0] addrs(input int a0, input int a1, input int a2);
    return {5'(a2), 5'(a1), 5'(a0)};
  endfunction

  // Leaves the bench in cycle t+1 after the accepting edge t
  task automatic fetch_start(input logic [2:0] en, input logic [14:0] ad);
    int n;
    n = 0;
    while (!bus.rd_ready_o && n < 20) begin
      tick();
      n++;
    end
    check("ready_before_req", bus.rd_ready_o, 1'b1);
    bus.rd_req_i     = 1'b1;
    bus.rd_port_en_i = en;
    bus.rd_addr_i    = ad;
    tick();
    bus.rd_req_i     = 1'b0;
  endtask

  // Counts cycles after acceptance until rd_valid_o; then checks the pulse ends and ready returns
  task automatic fetch_wait(input string tag, input int start_n, input int exp_n);
    int n;
    n = start_n;
    while (!bus.rd_valid_o && n < 20) begin
      tick();
      n++;
    end
    check(tag, n, exp_n);
    tick();
    check({tag, "_pulse_end"}, {bus.rd_valid_o, bus.rd_ready_o}, 2'b01);
  endtask

  task automatic peek(input int p, input int e, output logic [31:0] d);
    bus.rd_elem_i = 2'(e);
    #1;
    d = bus.rd_data_o[p*32 +: 32];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int pulses;

    bus.rd_req_i = 1'b0;  bus.rd_port_en_i = '0; bus.rd_addr_i = '0; bus.rd_elem_i = '0;
    bus.wr_valid_i = 1'b0; bus.wr_addr_i = '0; bus.wr_elem_i = '0; bus.wr_be_i = '0;
    bus.wdata_i = '0; bus.mask_en_i = 1'b1;

    // Reset state
    #12;
    check("rst_rd_ready", bus.rd_ready_o, 1'b0);
    check("rst_rd_valid", bus.rd_valid_o, 1'b0);
    check("rst_wr_ready", bus.wr_ready_o, 1'b0);
    check("rst_rd_data", bus.rd_data_o, 96'h0);
    check("rst_mask", bus.mask_rdata_o, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("post_rst_ready", {bus.rd_ready_o, bus.wr_ready_o}, 2'b11);

    // Test 1: single port fetch of v5
    wr(5, 0, 32'h11, 4'hF);
    wr(5, 1, 32'h22, 4'hF);
    wr(5, 2, 32'h33, 4'hF);
    wr(5, 3, 32'h44, 4'hF);
    fetch_start(3'b001, addrs(5, 0, 0));
    fetch_wait("t1_latency", 1, 2);
    for (int e = 0; e < 4; e++) begin
      peek(0, e, d);
      check($sformatf("t1_p0_e%0d", e), d, 32'h11 * (e + 1));
    end
    check("t1_p12_zero", bus.rd_data_o[95:32], 64'h0);

    // Test 2: enables 101, rd_req pulse during FETCH ignored
    wr(1, 0, 32'h101, 4'hF);
    wr(2, 0, 32'h202, 4'hF);
    wr(3, 0, 32'h303, 4'hF);
    fetch_start(3'b101, addrs(1, 2, 3));
    bus.rd_req_i = 1'b1;
    bus.rd_port_en_i = 3'b111;
    tick();
    bus.rd_req_i = 1'b0;
    fetch_wait("t2_latency", 2, 3);
    peek(0, 0, d); check("t2_p0", d, 32'h101);
    peek(1, 0, d); check("t2_p1_zero", d, 32'h0);
    peek(2, 0, d); check("t2_p2", d, 32'h303);
    pulses = 0;
    repeat (4) begin
      if (bus.rd_valid_o) pulses++;
      tick();
    end
    check("t2_no_requeue", pulses, 0);

    // Test 3: byte enables and mask shadow
    wr(0, 0, 32'hAABBCCDD, 4'hF);
    wr(0, 0, 32'h11223344, 4'b0101);
    bus.mask_en_i = 1'b1; #1;
    check("t3_mask_on", bus.mask_rdata_o, 32'hAA22CC44);
    bus.mask_en_i = 1'b0; #1;
    check("t3_mask_off", bus.mask_rdata_o, 32'h0);
    bus.mask_en_i = 1'b1;
    fetch_start(3'b001, addrs(0, 0, 0));
    fetch_wait("t3_latency", 1, 2);
    peek(0, 0, d); check("t3_storage", d, 32'hAA22CC44);

    // Test 4: forwarding into port 1 capture of v7
    for (int e = 0; e < 4; e++) wr(7, e, 32'h70 + e, 4'hF);
    wr(1, 0, 32'h1111, 4'hF);
    fetch_start(3'b111, addrs(1, 7, 2));
    tick();
    wr(7, 2, 32'hDEADBEEF, 4'hF);
    fetch_wait("t4_latency", 3, 4);
    peek(1, 0, d); check("t4_p1_e0", d, 32'h70);
    peek(1, 1, d); check("t4_p1_e1", d, 32'h71);
    peek(1, 2, d); check("t4_p1_e2_fwd", d, 32'hDEADBEEF);
    peek(1, 3, d); check("t4_p1_e3", d, 32'h73);
    peek(0, 0, d); check("t4_p0", d, 32'h1111);
    peek(2, 0, d); check("t4_p2", d, 32'h202);

    // Test 5: no enables
    fetch_start(3'b000, addrs(5, 5, 5));
    fetch_wait("t5_latency", 1, 1);
    peek(0, 0, d); check("t5_data_e0", bus.rd_data_o, 96'h0);
    peek(0, 3, d); check("t5_data_e3", bus.rd_data_o, 96'h0);

    // Test 6: reset during FETCH
    fetch_start(3'b111, addrs(5, 5, 5));
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", bus.rd_valid_o, 1'b0);
    check("t6_rst_readys", {bus.rd_ready_o, bus.wr_ready_o}, 2'b00);
    check("t6_rst_data", bus.rd_data_o, 96'h0);
    check("t6_rst_mask", bus.mask_rdata_o, 32'h0);
    pulses = 0;
    repeat (2) begin
      tick();
      if (bus.rd_valid_o) pulses++;
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) begin
      tick();
      if (bus.rd_valid_o) pulses++;
    end
    check("t6_no_pulse", pulses, 0);
    check("t6_ready_back", {bus.rd_ready_o, bus.wr_ready_o}, 2'b11);
    fetch_start(3'b001, addrs(5, 0, 0));
    fetch_wait("t6_latency", 1, 2);
    peek(0, 0, d); check("t6_v5_e0_zero", d, 32'h0);
    peek(0, 3, d); check("t6_v5_e3_zero", d, 32'h0);
    check("t6_mask_zero", bus.mask_rdata_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vrf_seq_nport.md
# vrf_seq_nport

Flip-flop vector register file for one vector lane group, with a parametrised number of sequentially fetched read operands, byte-enabled writes with valid/ready handshake, and a mask shadow register. Sits between the vector decode/issue stage and the lane ALUs. It replaces fixed A/B/C latch reads with a generic N-operand fetch sequencer. Same-cycle write-to-fetch forwarding gives operands read-after-write coherence.

## Interface
- DATA_WIDTH, 32, element width in bits; must be a multiple of 8
- REG_NUM, 32, number of vector registers
- ELEMS, 4, elements per register (one per lane)
- RD_PORTS, 3, number of read operands per request
- ADDR_B, $clog2(REG_NUM), register address width (derived)
- ELEM_B, $clog2(ELEMS), element index width (derived)
- BE_W, DATA_WIDTH/8, byte-enable width (derived)

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  reset, asynchronous, active-low
- rd_req_i  in  1  operand fetch request
- rd_ready_o  out  1  fetch request accepted when high together with rd_req_i
- rd_port_en_i  in  RD_PORTS  per-operand enable; bit p selects operand p
- rd_addr_i  in  RD_PORTS*ADDR_B  operand register addresses; port p at bits [p*ADDR_B +: ADDR_B]
- rd_valid_o  out  1  one-cycle pulse: all enabled operands captured
- rd_elem_i  in  ELEM_B  element select for the operand outputs
- rd_data_o  out  RD_PORTS*DATA_WIDTH  operand p element rd_elem_i, at bits [p*DATA_WIDTH +: DATA_WIDTH]
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accepted when high together with wr_valid_i
- wr_addr_i  in  ADDR_B  write register
- wr_elem_i  in  ELEM_B  write element
- wr_be_i  in  BE_W  byte enables
- wdata_i  in  DATA_WIDTH  write data
- mask_en_i  in  1  mask in use
- mask_rdata_o  out  DATA_WIDTH  v0 element 0 shadow when mask_en_i is high, else 0

## Operation
- Storage: REG_NUM×ELEMS×DATA_WIDTH flops, all cleared on reset. A write fires when wr_valid_i && wr_ready_o, and updates only the bytes where wr_be_i=1.
- wr_ready_o is 1 whenever out of reset. It is 0 while resetn_i is low.
- Mask shadow mask_q: cleared on reset. It is updated with the same byte-enable merge on any fired write where wr_addr_i==0 and wr_elem_i==0.
- Fetch FSM states: IDLE, FETCH, DONE.
  - IDLE: rd_ready_o=1. On rd_req_i, latch rd_port_en_i and rd_addr_i. Buffers of disabled ports are cleared to 0. Go to FETCH if any enable is set; otherwise go to DONE.
  - FETCH: a port counter visits enabled ports in ascending index order and skips disabled ports. Each cycle it captures all ELEMS elements of the addressed register into operand buffer p. After the last enabled port, go to DONE.
  - DONE: rd_valid_o=1 and rd_ready_o=0. Go to IDLE.
- Forwarding: if a write fires in the same cycle that a register is captured, and the register matches, the captured element wr_elem_i takes the byte-merged new value.
- rd_data_o[p] = opbuf[p][rd_elem_i], combinational from the buffers. Buffers hold until the next acceptance or reset.
- rd_req_i outside IDLE is ignored and is not queued.
- Duplicate addresses across ports are legal; each enabled port is fetched independently.

## Timing
- Reset values: rd_ready_o=0 during reset, 1 after. rd_valid_o=0. wr_ready_o=0 during reset, 1 after. rd_data_o=0. mask_rdata_o=0.
- Request accepted at edge t with k enabled ports:
  - FETCH occupies cycles t+1..t+k, one port per cycle.
  - rd_valid_o is high in cycle t+k+1.
  - rd_ready_o is high again in cycle t+k+2.
  - With k=0, rd_valid_o is high in cycle t+1.
- Write latency: a write fired at edge t is visible to a fetch capturing at edge t (via forwarding) and in mask_rdata_o after edge t.
- Reset mid-fetch: FSM returns to IDLE, buffers clear, rd_valid_o=0 immediately (asynchronous). No pulse appears after release.
- Simultaneous: a fired write and the IDLE acceptance in the same cycle do not interact. A write landing before the target port's capture cycle is seen through storage.

## Test plan
- Reset, then write v5 elements 0..3 = 0x11,0x22,0x33,0x44 with be=0xF; fetch ports {0}, addr 5 -> rd_valid_o in cycle t+2; rd_data_o[0] for elem 0..3 = 0x11..0x44; ports 1,2 read 0.
- Fetch RD_PORTS=3, enables 3'b101, addrs {v1,v2,v3} -> only ports 0 and 2 captured; port 1 reads 0; rd_valid_o in cycle t+3; rd_req_i pulses during FETCH are ignored.
- Byte-enable: v0 elem 0 = 0xAABBCCDD, then write 0x11223344 with be=4'b0101 -> storage and mask_rdata_o (mask_en_i=1) = 0xAA22CC44; with mask_en_i=0 -> 0.
- Forwarding: the cycle port 1 captures v7, fire write v7 elem 2 = 0xDEADBEEF -> rd_data_o[1] elem 2 = 0xDEADBEEF; other elements keep old values.
- Enables all zero -> rd_valid_o in cycle t+1; all rd_data_o = 0.
- Assert resetn_i low during FETCH -> rd_valid_o never pulses; all outputs 0; after release, storage is zero and a new fetch succeeds.
